// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative restoring integer divider for DIV/DIVU in the execute stage.
//   Resolves one quotient bit per clock. Results are held until the next
//   accepted request completes.
//
//   Latency from the accepting edge k:
//     normal         : outputs load at edge k+WIDTH+1, done in the cycle after
//     divide by zero : outputs load at edge k+1, done in the cycle after
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   request, accepted only while ready=1
//   d_signed   in   1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   src_a      in   dividend; sampled with start
//   src_b      in   divisor; sampled with start
//   ready      out  idle, able to accept start
//   done       out  single-cycle pulse, results valid
//   quotient   out  registered quotient
//   remainder  out  registered remainder
//   div_zero   out  divisor was zero (held with the results)
// -----------------------------------------------------------------------------
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             d_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic             sgn_q,    sgn_d;     // signed operation
  logic             neg_a_q,  neg_a_d;   // dividend was negative
  logic             neg_b_q,  neg_b_d;   // divisor was negative
  logic             zero_q,   zero_d;    // divisor was zero
  logic [WIDTH-1:0] rem_q,    rem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q,    dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q,    dvs_d;     // divisor magnitude
  logic [CW-1:0]    cnt_q,    cnt_d;     // iteration counter
  logic [WIDTH-1:0] quo_q,    quo_d;
  logic [WIDTH-1:0] rmd_q,    rmd_d;
  logic             dz_q,     dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path through this block leaves one unassigned and no latch is inferred.
    state_d = state_q;
    sgn_d   = sgn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    zero_d  = zero_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;

    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor. A negative trial result therefore always
    // lands with bit WIDTH set, while a non-negative one always fits in WIDTH
    // bits: bit WIDTH alone is the sign of the trial subtraction.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d   = d_signed;
          neg_a_d = d_signed & src_a[WIDTH-1];
          neg_b_d = d_signed & src_b[WIDTH-1];
          zero_d  = (src_b == '0);
          dvd_d   = (d_signed && src_a[WIDTH-1]) ? -src_a : src_a;
          dvs_d   = (d_signed && src_b[WIDTH-1]) ? -src_b : src_b;
          rem_d   = '0;
          cnt_d   = '0;
          if (src_b == '0) begin
            // No iterations: keep the raw dividend for the remainder output.
            dvd_d   = src_a;
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (diff[WIDTH]) begin
          rem_d = shifted[WIDTH-1:0];               // restore
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff[WIDTH-1:0];                  // keep difference
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end

      FIX: begin
        if (zero_q) begin
          quo_d = '1;
          rmd_d = dvd_q;
          dz_d  = 1'b1;
        end else begin
          // Most-negative / -1 needs no special case: both signs negative,
          // so the magnitude quotient 2**(WIDTH-1) is passed through as is.
          quo_d = (sgn_q && (neg_a_q != neg_b_q)) ? -dvd_q : dvd_q;
          rmd_d = (sgn_q && neg_a_q) ? -rem_q : rem_q;
          dz_d  = 1'b0;
        end
        state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      zero_q  <= zero_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule
